// File: rtl/fifo_read_checker_pkg.sv
// Shared constants for the FX3 read-path pattern checker: state encodings,
// default widths and LED bit positions.
package fifo_read_checker_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned WCNT_W_DEF = 24;
    localparam int unsigned PCNT_W_DEF = 16;
    localparam int unsigned ECNT_W_DEF = 8;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_SYNC  = 2'd1;
    localparam logic [STATE_W-1:0] ST_CHECK = 2'd2;

    localparam int unsigned LED_W        = 8;
    localparam int unsigned LED_LOCK_BIT = 7;
    localparam int unsigned LED_ERR_BIT  = 6;
    localparam int unsigned LED_CNT_W    = 6;

endpackage

// File: rtl/fifo_read_checker_sat_counter.sv
// Up-counter with synchronous clear; either saturates at all-ones or wraps,
// selected by SATURATE.
module fifo_read_checker_sat_counter #(
    parameter int unsigned W        = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_hold;

    assign w_hold = SATURATE && (r_count == {W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_hold) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fifo_read_checker.sv
// Loopback-integrity monitor for FX3 read transfers: checks registered read
// words against an incrementing pattern and reports counts and LED status.
module fifo_read_checker
    import fifo_read_checker_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned WCNT_W = WCNT_W_DEF,
    parameter int unsigned PCNT_W = PCNT_W_DEF,
    parameter int unsigned ECNT_W = ECNT_W_DEF
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic              Enable,
    input  logic              RdValid,
    input  logic [DATA_W-1:0] RdData,
    input  logic              LastRDData,
    input  logic              Select,
    output logic              Locked,
    output logic              ErrorFlag,
    output logic [WCNT_W-1:0] WordCount,
    output logic [PCNT_W-1:0] PacketCount,
    output logic [ECNT_W-1:0] ErrorCount,
    output logic [LED_W-1:0]  LED
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_last;

    logic [DATA_W-1:0] r_expected;
    logic [DATA_W-1:0] w_expected_nxt;
    logic              r_locked;
    logic              w_locked_nxt;
    logic              r_err_flag;
    logic              w_err_flag_nxt;

    logic w_cnt_clr;
    logic w_word_inc;
    logic w_pkt_inc;
    logic w_err_inc;
    logic w_mismatch;

    // Input stage; a word captured while idle is never checked, which also
    // drops the word arriving on the IDLE->SYNC edge.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= RdValid && (r_state != ST_IDLE);
            r_s1_data  <= RdData;
            r_s1_last  <= LastRDData;
        end
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_expected <= '0;
            r_locked   <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_expected <= w_expected_nxt;
            r_locked   <= w_locked_nxt;
            r_err_flag <= w_err_flag_nxt;
        end
    end

    assign w_mismatch = (r_s1_data != r_expected);

    // On every accepted word the next expected value is word+1, which is both
    // the normal increment and the resync point after a discontinuity.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_locked_nxt   = r_locked;
        w_err_flag_nxt = r_err_flag;
        w_cnt_clr      = 1'b0;
        w_word_inc     = 1'b0;
        w_pkt_inc      = 1'b0;
        w_err_inc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Enable) begin
                    w_state_nxt    = ST_SYNC;
                    w_cnt_clr      = 1'b1;
                    w_locked_nxt   = 1'b0;
                    w_err_flag_nxt = 1'b0;
                end
            end
            ST_SYNC: begin
                if (!Enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_s1_valid) begin
                    w_state_nxt    = ST_CHECK;
                    w_expected_nxt = r_s1_data + DATA_W'(1);
                    w_locked_nxt   = 1'b1;
                    w_word_inc     = 1'b1;
                    w_pkt_inc      = r_s1_last;
                end
            end
            ST_CHECK: begin
                if (!Enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_s1_valid) begin
                    w_expected_nxt = r_s1_data + DATA_W'(1);
                    w_word_inc     = 1'b1;
                    w_pkt_inc      = r_s1_last;
                    if (w_mismatch) begin
                        w_err_inc      = 1'b1;
                        w_err_flag_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    fifo_read_checker_sat_counter #(.W(WCNT_W), .SATURATE(1'b0)) u_word_cnt (
        .i_clk   (PCLK),
        .i_rst   (RESET),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_word_inc),
        .o_count (WordCount)
    );

    fifo_read_checker_sat_counter #(.W(PCNT_W), .SATURATE(1'b0)) u_pkt_cnt (
        .i_clk   (PCLK),
        .i_rst   (RESET),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_pkt_inc),
        .o_count (PacketCount)
    );

    fifo_read_checker_sat_counter #(.W(ECNT_W), .SATURATE(1'b1)) u_err_cnt (
        .i_clk   (PCLK),
        .i_rst   (RESET),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_err_inc),
        .o_count (ErrorCount)
    );

    assign Locked    = r_locked;
    assign ErrorFlag = r_err_flag;

    // LED page: word-count MSBs or error-count LSBs; Select acts immediately.
    always_comb begin
        LED                = '0;
        LED[LED_LOCK_BIT]  = r_locked;
        LED[LED_ERR_BIT]   = r_err_flag;
        LED[LED_CNT_W-1:0] = Select ? WordCount[WCNT_W-1 -: LED_CNT_W]
                                    : ErrorCount[LED_CNT_W-1:0];
    end

endmodule

// File: tb/tb_fifo_read_checker.sv
// Directed bench for fifo_read_checker with a per-edge reference model feeding
// a scoreboard queue, plus fixed-value checks at the end of each scenario.
module tb_fifo_read_checker;

    logic        PCLK = 1'b0;
    logic        RESET;
    logic        Enable;
    logic        RdValid;
    logic [31:0] RdData;
    logic        LastRDData;
    logic        Select;
    logic        Locked;
    logic        ErrorFlag;
    logic [23:0] WordCount;
    logic [15:0] PacketCount;
    logic [7:0]  ErrorCount;
    logic [7:0]  LED;

    always #5 PCLK = ~PCLK;

    fifo_read_checker dut (
        .PCLK        (PCLK),
        .RESET       (RESET),
        .Enable      (Enable),
        .RdValid     (RdValid),
        .RdData      (RdData),
        .LastRDData  (LastRDData),
        .Select      (Select),
        .Locked      (Locked),
        .ErrorFlag   (ErrorFlag),
        .WordCount   (WordCount),
        .PacketCount (PacketCount),
        .ErrorCount  (ErrorCount),
        .LED         (LED)
    );

    typedef struct {
        logic [23:0] wc;
        logic [15:0] pc;
        logic [7:0]  ec;
        logic        ef;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // reference model state (0 idle, 1 sync, 2 check)
    int          m_state = 0;
    logic        m_s1v   = 1'b0;
    logic [31:0] m_s1d   = '0;
    logic        m_s1l   = 1'b0;
    logic [31:0] m_exp   = '0;
    logic [23:0] m_wc    = '0;
    logic [15:0] m_pc    = '0;
    logic [7:0]  m_ec    = '0;
    logic        m_ef    = 1'b0;
    logic        m_lk    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Effect of one clock edge given the inputs presented before it.
    task automatic model_edge(input logic rst, input logic en, input logic v,
                              input logic [31:0] d, input logic last);
        int          old_st;
        logic        pv;
        logic [31:0] pd;
        logic        pl;
        old_st = m_state;
        pv = m_s1v;
        pd = m_s1d;
        pl = m_s1l;
        if (rst) begin
            m_state = 0; m_s1v = 1'b0; m_s1d = '0; m_s1l = 1'b0; m_exp = '0;
            m_wc = '0; m_pc = '0; m_ec = '0; m_ef = 1'b0; m_lk = 1'b0;
        end else begin
            if (old_st == 0) begin
                if (en) begin
                    m_state = 1;
                    m_wc = '0; m_pc = '0; m_ec = '0; m_ef = 1'b0; m_lk = 1'b0;
                end
            end else if (!en) begin
                m_state = 0;
            end else if (pv) begin
                m_wc = m_wc + 24'd1;
                if (pl) m_pc = m_pc + 16'd1;
                if (old_st == 2 && pd != m_exp) begin
                    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
                    m_ef = 1'b1;
                end
                if (old_st == 1) m_lk = 1'b1;
                m_exp = pd + 32'd1;
                m_state = 2;
            end
            m_s1v = v;
            if (old_st == 0) m_s1v = 1'b0;
            m_s1d = d;
            m_s1l = last;
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic v,
                        input logic [31:0] d, input logic last);
        exp_t        e;
        logic [7:0]  led_e;
        RESET = rst; Enable = en; RdValid = v; RdData = d; LastRDData = last;
        model_edge(rst, en, v, d, last);
        e = '{wc: m_wc, pc: m_pc, ec: m_ec, ef: m_ef, lk: m_lk};
        sb.push_back(e);
        @(posedge PCLK);
        #1;
        e = sb.pop_front();
        led_e = {e.lk, e.ef, Select ? e.wc[23:18] : e.ec[5:0]};
        check("sb_word_count",   32'(WordCount),   32'(e.wc));
        check("sb_packet_count", 32'(PacketCount), 32'(e.pc));
        check("sb_error_count",  32'(ErrorCount),  32'(e.ec));
        check("sb_error_flag",   32'(ErrorFlag),   32'(e.ef));
        check("sb_locked",       32'(Locked),      32'(e.lk));
        check("sb_led",          32'(LED),         32'(led_e));
    endtask

    task automatic start();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic flush();
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    logic [31:0] vec[$];

    initial begin
        RESET = 1'b1; Enable = 1'b0; RdValid = 1'b0; RdData = '0;
        LastRDData = 1'b0; Select = 1'b0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_word_count",  32'(WordCount),  32'd0);
        check("rst_error_count", 32'(ErrorCount), 32'd0);
        check("rst_locked",      32'(Locked),     32'd0);
        check("rst_led",         32'(LED),        32'd0);

        // 256-word clean incrementing stream
        start();
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 1'b1, 32'h10 + 32'(i), 1'b0);
        flush();
        check("inc_word_count",  32'(WordCount),  32'd256);
        check("inc_error_count", 32'(ErrorCount), 32'd0);
        check("inc_error_flag",  32'(ErrorFlag),  32'd0);
        check("inc_locked",      32'(Locked),     32'd1);

        // single discontinuity with resync
        start();
        vec = '{32'd5, 32'd6, 32'd7, 32'd20, 32'd21, 32'd22};
        foreach (vec[i]) step(1'b0, 1'b1, 1'b1, vec[i], 1'b0);
        flush();
        check("gap_error_count", 32'(ErrorCount), 32'd1);
        check("gap_error_flag",  32'(ErrorFlag),  32'd1);
        check("gap_word_count",  32'(WordCount),  32'd6);

        // expected value wraps through zero
        start();
        vec = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        foreach (vec[i]) step(1'b0, 1'b1, 1'b1, vec[i], 1'b0);
        flush();
        check("wrap_error_count", 32'(ErrorCount), 32'd0);
        check("wrap_word_count",  32'(WordCount),  32'd4);

        // three 4-word packets, valid every other cycle
        start();
        for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < 4; w++) begin
                step(1'b0, 1'b1, 1'b1, 32'd100 + 32'(p * 4 + w), (w == 3));
                step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
            end
        end
        flush();
        check("pkt_packet_count", 32'(PacketCount), 32'd3);
        check("pkt_word_count",   32'(WordCount),   32'd12);
        check("pkt_error_count",  32'(ErrorCount),  32'd0);

        // constant data: error counter saturates
        start();
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
        flush();
        check("sat_error_count", 32'(ErrorCount), 32'd255);
        check("sat_word_count",  32'(WordCount),  32'd300);
        check("sat_led_page0",   32'(LED),        32'hFF);
        Select = 1'b1;
        #1;
        check("sat_led_page1",   32'(LED),        32'hC0);
        Select = 1'b0;
        #1;
        check("sat_led_back",    32'(LED),        32'hFF);

        // enable drop mid-stream, re-entry, then reset mid-stream
        start();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 32'd1000 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'd1010 + 32'(i), 1'b0);
        check("off_word_count", 32'(WordCount), 32'd9);
        check("off_locked",     32'(Locked),    32'd1);
        step(1'b0, 1'b1, 1'b1, 32'd5000, 1'b0);
        check("reen_cleared",   32'(WordCount), 32'd0);
        check("reen_locked",    32'(Locked),    32'd0);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 1'b1, 32'd5000 + 32'(i), 1'b0);
        flush();
        check("reen_word_count",  32'(WordCount),  32'd7);
        check("reen_error_count", 32'(ErrorCount), 32'd0);
        check("reen_error_flag",  32'(ErrorFlag),  32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 32'd7 * 32'(i), (i == 2));
        step(1'b1, 1'b1, 1'b1, 32'd99, 1'b1);
        check("mrst_word_count",   32'(WordCount),   32'd0);
        check("mrst_packet_count", 32'(PacketCount), 32'd0);
        check("mrst_error_count",  32'(ErrorCount),  32'd0);
        check("mrst_flags",        32'({Locked, ErrorFlag}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
